// File: rtl/cic_ctrl_pkg.sv
// Shared types and constants for the CIC decimator sequencing controller.
package cic_ctrl_pkg;

    localparam int unsigned R_MAX_DEF = 16;
    localparam int unsigned R_DEF_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

    // Width needed to hold a ratio in 0..rmax
    function automatic int unsigned wr_of(input int unsigned rmax);
        return $clog2(rmax + 1);
    endfunction

endpackage

// File: rtl/cic_val_delay.sv
// Fixed-depth valid+tag shift register; the tag rides alongside its valid.
module cic_val_delay #(
    parameter int unsigned D  = 1,
    parameter int unsigned TW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vld_in,
    input  logic [TW-1:0] tag_in,
    output logic          vld_out,
    output logic [TW-1:0] tag_out
);

    logic [D-1:0]         vld_sr;
    logic [D-1:0][TW-1:0] tag_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
            tag_sr <= '0;
        end else begin
            vld_sr[0] <= vld_in;
            tag_sr[0] <= tag_in;
            for (int unsigned i = 1; i < D; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                tag_sr[i] <= tag_sr[i-1];
            end
        end
    end

    assign vld_out = vld_sr[D-1];
    assign tag_out = tag_sr[D-1];

endmodule

// File: rtl/cic_dec_ctrl.sv
// CIC decimator sequencing controller: phase counting, decimation strobe,
// warm-up masking and boundary-aligned ratio reconfiguration (CIC_WARMUP_MASK_EN).
module cic_dec_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int unsigned R_MAX   = R_MAX_DEF,
    parameter int unsigned R_DEF   = R_DEF_DEF,
    parameter int unsigned Ncomb   = 3,
    parameter int unsigned LAT_INT = 3
) (
    input  logic                    clk,
    input  logic                    ic_rst,
    input  logic                    ic_val_data,
    input  logic                    ic_cfg_load,
    input  logic [wr_of(R_MAX)-1:0] id_cfg_r,
    output logic                    oc_cfg_ack,
    output logic                    oc_cfg_err,
    output logic                    oc_int_en,
    output logic                    oc_dec_strobe,
    output logic                    oc_val_data,
    output logic [wr_of(R_MAX)-1:0] od_phase,
    output logic [1:0]              od_state
);

    localparam int unsigned WR = wr_of(R_MAX);
`ifdef CIC_WARMUP_MASK_EN
    localparam int unsigned CW = $clog2(Ncomb + 1);
    logic [CW-1:0] warm_q, warm_d;
`endif

    state_e        state_q, state_d;
    logic [WR-1:0] r_q, r_d;
    logic [WR-1:0] phase_q, phase_d;
    logic [WR-1:0] pend_r_q, pend_r_d;
    logic          pend_q, pend_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;

    logic          v_int;
    logic          int_tag_unused;
    logic          v_comb;
    logic          comb_mask;
    logic          strobe_mask;
    logic          cfg_ok;
    logic          apply;
    logic [WR-1:0] req_r;

    assign oc_int_en = ic_val_data;

    cic_val_delay #(
        .D  (LAT_INT),
        .TW (1)
    ) u_int_dly (
        .clk     (clk),
        .rst_n   (ic_rst),
        .vld_in  (ic_val_data),
        .tag_in  (1'b0),
        .vld_out (v_int),
        .tag_out (int_tag_unused)
    );

    assign oc_dec_strobe = v_int && (phase_q == r_q - WR'(1));

    // Mask decision is frozen at strobe time and travels with the valid
`ifdef CIC_WARMUP_MASK_EN
    assign strobe_mask = (state_q != ST_RUN);
`else
    assign strobe_mask = 1'b0;
`endif

    cic_val_delay #(
        .D  (Ncomb),
        .TW (1)
    ) u_comb_dly (
        .clk     (clk),
        .rst_n   (ic_rst),
        .vld_in  (oc_dec_strobe),
        .tag_in  (strobe_mask),
        .vld_out (v_comb),
        .tag_out (comb_mask)
    );

    assign oc_val_data = v_comb && !comb_mask;

    assign cfg_ok = ic_cfg_load && (id_cfg_r != '0) && (id_cfg_r <= WR'(R_MAX));
    assign req_r  = cfg_ok ? id_cfg_r : pend_r_q;
    assign apply  = (cfg_ok || pend_q) && ((state_q == ST_IDLE) || oc_dec_strobe);

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        phase_d  = phase_q;
        pend_d   = pend_q;
        pend_r_d = pend_r_q;
        ack_d    = 1'b0;
        err_d    = ic_cfg_load && !cfg_ok;
`ifdef CIC_WARMUP_MASK_EN
        warm_d   = warm_q;
`endif

        if (cfg_ok) begin
            pend_d   = 1'b1;
            pend_r_d = id_cfg_r;
        end

        if (v_int) begin
            phase_d = oc_dec_strobe ? '0 : phase_q + WR'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (v_int) begin
`ifdef CIC_WARMUP_MASK_EN
                    warm_d  = CW'(oc_dec_strobe);
                    state_d = (warm_d == CW'(Ncomb)) ? ST_RUN : ST_WARMUP;
`else
                    state_d = ST_RUN;
`endif
                end
            end
            ST_WARMUP: begin
`ifdef CIC_WARMUP_MASK_EN
                if (oc_dec_strobe) begin
                    warm_d = warm_q + CW'(1);
                    if (warm_d == CW'(Ncomb)) begin
                        state_d = ST_RUN;
                    end
                end
`else
                state_d = ST_RUN;
`endif
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // New ratio takes effect after the current strobe; phase restarts
        if (apply) begin
            r_d     = req_r;
            phase_d = '0;
            pend_d  = 1'b0;
            ack_d   = 1'b1;
`ifdef CIC_WARMUP_MASK_EN
            if (state_q != ST_IDLE) begin
                state_d = ST_WARMUP;
                warm_d  = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge ic_rst) begin
        if (!ic_rst) begin
            state_q  <= ST_IDLE;
            r_q      <= WR'(R_DEF);
            phase_q  <= '0;
            pend_q   <= 1'b0;
            pend_r_q <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef CIC_WARMUP_MASK_EN
            warm_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            phase_q  <= phase_d;
            pend_q   <= pend_d;
            pend_r_q <= pend_r_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
`ifdef CIC_WARMUP_MASK_EN
            warm_q   <= warm_d;
`endif
        end
    end

    assign oc_cfg_ack = ack_q;
    assign oc_cfg_err = err_q;
    assign od_phase   = phase_q;
    assign od_state   = state_q;

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Self-checking bench for cic_dec_ctrl: directed timing scenarios plus random
// traffic against a count-based reference model (honours CIC_WARMUP_MASK_EN).
module tb_cic_dec_ctrl;

    localparam int unsigned R_MAX = 16;
    localparam int unsigned WR    = 5;
    localparam int          LAT   = 3;
    localparam int          NC    = 3;
`ifdef CIC_WARMUP_MASK_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          ic_rst;
    logic          ic_val_data;
    logic          ic_cfg_load;
    logic [WR-1:0] id_cfg_r;
    logic          oc_cfg_ack;
    logic          oc_cfg_err;
    logic          oc_int_en;
    logic          oc_dec_strobe;
    logic          oc_val_data;
    logic [WR-1:0] od_phase;
    logic [1:0]    od_state;

    cic_dec_ctrl #(
        .R_MAX   (16),
        .R_DEF   (4),
        .Ncomb   (3),
        .LAT_INT (3)
    ) dut (
        .clk           (clk),
        .ic_rst        (ic_rst),
        .ic_val_data   (ic_val_data),
        .ic_cfg_load   (ic_cfg_load),
        .id_cfg_r      (id_cfg_r),
        .oc_cfg_ack    (oc_cfg_ack),
        .oc_cfg_err    (oc_cfg_err),
        .oc_int_en     (oc_int_en),
        .oc_dec_strobe (oc_dec_strobe),
        .oc_val_data   (oc_val_data),
        .od_phase      (od_phase),
        .od_state      (od_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: ratio, valids counted since the last phase restart,
    // strobes seen since the last warm-up restart, pending request
    bit m_started;
    int m_r, m_cnt, m_warm, m_pend_r;
    bit m_pend, m_ack, m_err;
    bit vin_q[$];
    bit out_q[$];

    int first_stb, first_val, first_ack, stb_cnt, err_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_r       = 4;
        m_cnt     = 0;
        m_warm    = 0;
        m_pend    = 1'b0;
        m_pend_r  = 0;
        m_ack     = 1'b0;
        m_err     = 1'b0;
        vin_q.delete();
        out_q.delete();
        for (int i = 0; i < LAT; i++) vin_q.push_back(1'b0);
        for (int i = 0; i < NC; i++) out_q.push_back(1'b0);
        first_stb = -1;
        first_val = -1;
        first_ack = -1;
        stb_cnt   = 0;
        err_cnt   = 0;
    endtask

    task automatic model_cycle();
        bit vi, stb, msk, ok, apply;
        int req, exp_state;
        vi  = vin_q[0];
        stb = vi && ((m_cnt % m_r) == m_r - 1);
        msk = EN && (!m_started || m_warm < NC);
        exp_state = !m_started ? 0 : ((EN && m_warm < NC) ? 1 : 2);

        check("int_en", 32'(oc_int_en), 32'(ic_val_data));
        check("strobe", 32'(oc_dec_strobe), 32'(stb));
        check("val", 32'(oc_val_data), 32'(out_q[0]));
        check("phase", 32'(od_phase), 32'(m_cnt % m_r));
        check("state", 32'(od_state), 32'(exp_state));
        check("ack", 32'(oc_cfg_ack), 32'(m_ack));
        check("err", 32'(oc_cfg_err), 32'(m_err));

        if (oc_dec_strobe === 1'b1) begin
            stb_cnt++;
            if (first_stb < 0) first_stb = cyc;
        end
        if (oc_val_data === 1'b1 && first_val < 0) first_val = cyc;
        if (oc_cfg_ack === 1'b1 && first_ack < 0) first_ack = cyc;
        if (oc_cfg_err === 1'b1) err_cnt++;

        ok    = ic_cfg_load && id_cfg_r >= 1 && int'(id_cfg_r) <= int'(R_MAX);
        m_err = ic_cfg_load && !ok;
        req   = ok ? int'(id_cfg_r) : m_pend_r;
        apply = (ok || m_pend) && (!m_started || stb);
        if (ok) begin
            m_pend   = 1'b1;
            m_pend_r = int'(id_cfg_r);
        end
        if (vi) m_cnt++;
        if (stb && m_warm < NC) m_warm++;
        if (apply) begin
            if (m_started) m_warm = 0;
            m_r    = req;
            m_cnt  = 0;
            m_pend = 1'b0;
        end
        m_ack = apply;
        if (vi) m_started = 1'b1;
        void'(vin_q.pop_front());
        vin_q.push_back(ic_val_data);
        void'(out_q.pop_front());
        out_q.push_back(stb && !msk);
    endtask

    task automatic run_cycle(input logic v, input logic ld, input logic [WR-1:0] rv);
        @(posedge clk);
        #1;
        ic_val_data = v;
        ic_cfg_load = ld;
        id_cfg_r    = rv;
        @(negedge clk);
        model_cycle();
        cyc++;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once
    task automatic do_reset();
        @(posedge clk);
        #3;
        ic_rst      = 1'b0;
        ic_val_data = 1'b0;
        ic_cfg_load = 1'b0;
        id_cfg_r    = '0;
        #1;
        check("rst_strobe", 32'(oc_dec_strobe), 32'd0);
        check("rst_val", 32'(oc_val_data), 32'd0);
        check("rst_ack", 32'(oc_cfg_ack), 32'd0);
        check("rst_err", 32'(oc_cfg_err), 32'd0);
        check("rst_phase", 32'(od_phase), 32'd0);
        check("rst_state", 32'(od_state), 32'd0);
        check("rst_int_en", 32'(oc_int_en), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        ic_rst = 1'b1;
        cyc    = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1);
    end

    initial begin
        logic          ld;
        logic [WR-1:0] rv;
        ic_rst      = 1'b0;
        ic_val_data = 1'b0;
        ic_cfg_load = 1'b0;
        id_cfg_r    = '0;

        // Continuous input: strobe at 6, first unmasked output at 21 (9 unmasked build)
        do_reset();
        for (int i = 0; i < 40; i++) run_cycle(1'b1, 1'b0, '0);
        check("first_stb", 32'(first_stb), 32'd6);
        check("first_val", 32'(first_val), EN ? 32'd21 : 32'd9);

        // Every other cycle valid: 4th valid at cycle 6, strobe at 9
        do_reset();
        for (int i = 0; i < 60; i++) run_cycle(1'((i % 2) == 0), 1'b0, '0);
        check("gap_first_stb", 32'(first_stb), 32'd9);

        // R=2 loaded mid-phase at 28; R=4 strobe at 30 completes, ack at 31
        do_reset();
        for (int i = 0; i < 60; i++) run_cycle(1'b1, 1'(i == 28), WR'(2));
        check("reconf_ack_cyc", 32'(first_ack), 32'd31);

        // Rejected ratios 0 and 17, then R=1 strobes every cycle
        do_reset();
        for (int i = 0; i < 70; i++) begin
            ld = 1'((i == 25) || (i == 27) || (i == 45));
            rv = (i == 25) ? WR'(0) : ((i == 27) ? WR'(17) : WR'(1));
            if (i == 50) stb_cnt = 0;
            run_cycle(1'b1, ld, rv);
        end
        check("r1_strobes", 32'(stb_cnt), 32'd20);
        check("err_pulses", 32'(err_cnt), 32'd2);
        check("r1_ack_cyc", 32'(first_ack), 32'd47);

        // Reset between strobes; R returns to the default
        do_reset();
        for (int i = 0; i < 16; i++) run_cycle(1'b1, 1'(i == 8), WR'(7));
        do_reset();
        for (int i = 0; i < 30; i++) run_cycle(1'b1, 1'b0, '0);
        check("post_rst_first_stb", 32'(first_stb), 32'd6);

        // Random traffic with a reset partway through
        do_reset();
        for (int i = 0; i < 500; i++) begin
            if (i == 250) do_reset();
            run_cycle(1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 11) == 0),
                      WR'($urandom_range(0, 20)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cic_dec_ctrl.md
# cic_dec_ctrl

Sequencing controller for the CIC decimator datapath. It drives the integrator-chain enable at the input rate and counts integrator-output valids modulo R. It then issues the decimation strobe that clocks the comb chain (`cic_comb` stages) and produces the final output-valid, masking comb warm-up outputs. It also accepts run-time reconfiguration of the decimation ratio R, applied only on a decimation boundary.

## Interface
- `R_MAX`, 16, largest accepted decimation ratio.
- `R_DEF`, 4, ratio active after reset.
- `Ncomb`, 3, number of comb stages. Each stage has a latency of 1 cycle.
- `LAT_INT`, 3, integrator-chain latency in cycles from input valid to integrator-output valid.
- `clk`  in  1  system clock, rising edge.
- `ic_rst`  in  1  asynchronous, active-low reset.
- `ic_val_data`  in  1  input sample valid from the source.
- `ic_cfg_load`  in  1  request to load `id_cfg_r`.
- `id_cfg_r`  in  WR  requested ratio. `WR = $clog2(R_MAX+1)`, unsigned.
- `oc_cfg_ack`  out  1  one-cycle pulse when a new R has been applied.
- `oc_cfg_err`  out  1  one-cycle pulse when a request is rejected.
- `oc_int_en`  out  1  integrator enable.
- `oc_dec_strobe`  out  1  comb-chain `ic_val_data`.
- `oc_val_data`  out  1  final decimated-output valid.
- `od_phase`  out  WR  current phase count, range 0..R-1.
- `od_state`  out  2  FSM state, for debug.

## Operation
- `oc_int_en = ic_val_data`, purely combinational, never gated.
- `ic_val_data` is delayed LAT_INT cycles to form `v_int`.
- On each `v_int`, the phase counter increments; it wraps from R-1 to 0.
- `oc_dec_strobe` is high in a `v_int` cycle with phase == R-1.
- `oc_dec_strobe` is delayed Ncomb cycles to form `v_comb`.
- `oc_val_data = v_comb` and not masked.
- FSM states:
  - IDLE: after reset. The first `v_int` moves the FSM to WARMUP.
  - WARMUP: counts strobes. After Ncomb strobes the FSM moves to RUN. Comb outputs produced from these Ncomb strobes are masked.
  - RUN: steady state.
  - Applying a new R in RUN returns the FSM to WARMUP with the warm-up count cleared.
- Reconfiguration rules:
  - A request with `id_cfg_r` equal to 0 or greater than R_MAX is rejected. `oc_cfg_err` pulses the next cycle and no pending request is stored.
  - A valid request is stored as pending. A newer valid request overwrites it.
  - In IDLE, the pending R is applied immediately.
  - Otherwise the pending R is applied on the next strobe cycle. That strobe still uses the old R. Phase restarts at 0 under the new R.
  - `oc_cfg_ack` pulses the cycle after R is applied.
  - If load and strobe coincide, the request applies at that strobe.
- R = 1 is legal: every `v_int` is a strobe.
- Mask bookkeeping travels in the valid pipeline, one mask bit alongside each valid. This keeps outputs already in flight when the FSM changes state correctly masked or unmasked.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - phase 0;
  - R = R_DEF;
  - pending request cleared;
  - delay lines cleared.
- Reset mid-operation clears everything asynchronously. In-flight valids and pending requests are discarded.
- Strobe latency: the R-th accepted input valid is at cycle t; `oc_dec_strobe` is high at t+LAT_INT.
- Output latency: `oc_val_data` is high at t+LAT_INT+Ncomb.
- No backpressure; the controller accepts `ic_val_data` every cycle.
- `od_phase` and `od_state` are registered.

## Configuration
- Macro: `CIC_WARMUP_MASK_EN`.
  - Defined: the WARMUP state exists and masking is as described above.
  - Undefined: the FSM goes IDLE -> RUN and reconfiguration stays in RUN. Every strobe yields `oc_val_data`.

## Structure
- Shared package `cic_ctrl_pkg` holds:
  - the state enum typedef (IDLE, WARMUP, RUN);
  - the `WR` width function/constant;
  - defaults for R_MAX and R_DEF.
- One sub-module, `cic_val_delay`, a parameterised valid+tag shift register (depth D). It is instantiated twice: depth LAT_INT and depth Ncomb.

## Test plan
Bench parameters for all scenarios: R=4, LAT_INT=3, Ncomb=3, inputs continuously valid from cycle 0.
- Timing: first strobe at cycle 6, strobes every 4 cycles thereafter, first unmasked `oc_val_data` at cycle 6+12+3=21.
- Masking: with `CIC_WARMUP_MASK_EN` undefined, the same stimulus gives `oc_val_data` at cycles 9, 13, 17, ....
- Gapped input: valid on every other cycle gives a strobe every 8 cycles and `od_phase` holds during gaps.
- Reconfiguration in RUN:
  - load R=2 mid-phase;
  - old R=4 completes;
  - `oc_cfg_ack` is high the cycle after that strobe;
  - subsequent strobes come every 2 valids;
  - the next 3 outputs are masked.
- Invalid and edge R:
  - load R=0 or R=17: `oc_cfg_err` pulses and the strobe period is unchanged;
  - load R=1: a strobe on every `v_int`.
- Reset mid-operation: assert `ic_rst` low between strobes. All outputs drop to 0 immediately, R returns to 4, and the next run restarts in IDLE.
